// File: rtl/core_amo_unit.sv
// Sequential atomic memory operation engine: one AMO/LR/SC at a time, read-modify-write
// over a req/ack memory port, with a single LR reservation invalidated by snoops.
module core_amo_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_amo_valid,
    output logic                    o_amo_ready,
    input  logic [3:0]              i_amo_op,
    input  logic                    i_amo_word,
    input  logic [ADDR_WIDTH-1:0]   i_amo_addr,
    input  logic [DATA_WIDTH-1:0]   i_amo_wdata,
    output logic                    o_mem_rd_en,
    output logic                    o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    input  logic                    i_mem_ack,
    input  logic                    i_snoop_valid,
    input  logic [ADDR_WIDTH-1:0]   i_snoop_addr,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_resp_data,
    output logic                    o_resp_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_SC_CHK,
        ST_RESP
    } state_e;

    typedef enum logic [3:0] {
        OP_SWAP = 4'd0,
        OP_ADD  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_MAX  = 4'd5,
        OP_MIN  = 4'd6,
        OP_MAXU = 4'd7,
        OP_MINU = 4'd8,
        OP_LR   = 4'd9,
        OP_SC   = 4'd10
    } amo_op_e;

    function automatic logic [ADDR_WIDTH-1:0] granule(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] g;
        g            = a;
        g[OFF_W-1:0] = '0;
        return g;
    endfunction

    state_e                  state_q,     state_d;
    logic [3:0]              op_q,        op_d;
    logic                    word_q,      word_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]   opnd_q,      opnd_d;
    logic [DATA_WIDTH-1:0]   old_q,       old_d;
    logic                    sc_fail_q,   sc_fail_d;
    logic                    res_valid_q, res_valid_d;
    logic [ADDR_WIDTH-1:0]   res_addr_q,  res_addr_d;

    logic [ADDR_WIDTH-1:0]   addr_gran;
    logic [ADDR_WIDTH-1:0]   snoop_gran;
    logic                    snoop_on_addr;
    logic                    snoop_on_res;
    logic                    res_on_addr;
    logic                    op_illegal;

    logic [DATA_WIDTH-1:0]   old_ext;
    logic [DATA_WIDTH-1:0]   opnd_ext;
    logic [DATA_WIDTH-1:0]   result;
    logic [DATA_WIDTH-1:0]   wr_data_full;
    logic [STRB_W-1:0]       wstrb_full;

    assign addr_gran     = granule(addr_q);
    assign snoop_gran    = granule(i_snoop_addr);
    assign snoop_on_addr = i_snoop_valid && (snoop_gran == addr_gran);
    assign snoop_on_res  = i_snoop_valid && res_valid_q && (snoop_gran == res_addr_q);
    assign res_on_addr   = res_valid_q && (res_addr_q == addr_gran);
    assign op_illegal    = (op_q > OP_SC);

    // Word ops are evaluated on sign-extended lanes: sign extension preserves both signed
    // and unsigned ordering, so one full-width compare serves all four min/max flavours.
    if (DATA_WIDTH == 64) begin : g_dw64
        logic [31:0] old_lane;
        assign old_lane     = addr_q[2] ? old_q[63:32] : old_q[31:0];
        assign old_ext      = word_q ? {{32{old_lane[31]}}, old_lane} : old_q;
        assign opnd_ext     = word_q ? {{32{opnd_q[31]}}, opnd_q[31:0]} : opnd_q;
        assign wr_data_full = word_q ? {2{result[31:0]}} : result;
        assign wstrb_full   = word_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;
    end else begin : g_dw32
        assign old_ext      = old_q;
        assign opnd_ext     = opnd_q;
        assign wr_data_full = result;
        assign wstrb_full   = '1;
    end

    always_comb begin
        logic gt_s, lt_s, gt_u, lt_u;
        gt_s   = $signed(old_ext) > $signed(opnd_ext);
        lt_s   = $signed(old_ext) < $signed(opnd_ext);
        gt_u   = old_ext > opnd_ext;
        lt_u   = old_ext < opnd_ext;
        result = opnd_ext;
        case (op_q)
            OP_ADD:  result = old_ext + opnd_ext;
            OP_AND:  result = old_ext & opnd_ext;
            OP_OR:   result = old_ext | opnd_ext;
            OP_XOR:  result = old_ext ^ opnd_ext;
            OP_MAX:  result = gt_s ? old_ext : opnd_ext;
            OP_MIN:  result = lt_s ? old_ext : opnd_ext;
            OP_MAXU: result = gt_u ? old_ext : opnd_ext;
            OP_MINU: result = lt_u ? old_ext : opnd_ext;
            default: result = opnd_ext;
        endcase
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        word_d      = word_q;
        addr_d      = addr_q;
        opnd_d      = opnd_q;
        old_d       = old_q;
        sc_fail_d   = sc_fail_q;
        res_valid_d = res_valid_q && !snoop_on_res;
        res_addr_d  = res_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (i_amo_valid) begin
                    op_d      = i_amo_op;
                    word_d    = i_amo_word;
                    addr_d    = i_amo_addr;
                    opnd_d    = i_amo_wdata;
                    sc_fail_d = 1'b0;
                    if (i_amo_op <= OP_LR) begin
                        state_d = ST_RD;
                    end else if (i_amo_op == OP_SC) begin
                        state_d = ST_SC_CHK;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RD: begin
                if (i_mem_ack) begin
                    old_d = i_mem_rdata;
                    if (op_q == OP_LR) begin
                        // A snoop to the new granule in the ack cycle wins over the set.
                        res_valid_d = !snoop_on_addr;
                        res_addr_d  = addr_gran;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (i_mem_ack) begin
                    if (res_on_addr) begin
                        res_valid_d = 1'b0;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_SC_CHK: begin
                res_valid_d = 1'b0;
                if (res_on_addr && !snoop_on_addr) begin
                    sc_fail_d = 1'b0;
                    state_d   = ST_WR;
                end else begin
                    sc_fail_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= res_valid_d;
        end
    end

    // NOTE: datapath registers carry no reset; every output that exposes them is gated by
    // state, and each is rewritten before use in a new request.
    always_ff @(posedge i_clk) begin
        op_q       <= op_d;
        word_q     <= word_d;
        addr_q     <= addr_d;
        opnd_q     <= opnd_d;
        old_q      <= old_d;
        sc_fail_q  <= sc_fail_d;
        res_addr_q <= res_addr_d;
    end

    assign o_amo_ready  = (state_q == ST_IDLE);
    assign o_mem_rd_en  = (state_q == ST_RD);
    assign o_mem_wr_en  = (state_q == ST_WR);
    assign o_mem_addr   = (o_mem_rd_en || o_mem_wr_en) ? addr_gran : '0;
    assign o_mem_wdata  = o_mem_wr_en ? wr_data_full : '0;
    assign o_mem_wstrb  = o_mem_wr_en ? wstrb_full : '0;
    assign o_resp_valid = (state_q == ST_RESP);
    assign o_resp_err   = o_resp_valid && op_illegal;

    always_comb begin
        o_resp_data = '0;
        if (o_resp_valid && !op_illegal) begin
            if (op_q == OP_SC) begin
                o_resp_data[0] = sc_fail_q;
            end else begin
                o_resp_data = old_ext;
            end
        end
    end

endmodule

// File: tb/tb_core_amo_unit.sv
// Directed self-checking bench for core_amo_unit: a small byte-strobed memory responder
// acks every request immediately; each scenario task compares against hand-computed values.
module tb_core_amo_unit;

    localparam int DW = 64;
    localparam int AW = 64;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_amo_valid;
    logic            o_amo_ready;
    logic [3:0]      i_amo_op;
    logic            i_amo_word;
    logic [AW-1:0]   i_amo_addr;
    logic [DW-1:0]   i_amo_wdata;
    logic            o_mem_rd_en;
    logic            o_mem_wr_en;
    logic [AW-1:0]   o_mem_addr;
    logic [DW-1:0]   o_mem_wdata;
    logic [DW/8-1:0] o_mem_wstrb;
    logic [DW-1:0]   i_mem_rdata;
    logic            i_mem_ack;
    logic            i_snoop_valid;
    logic [AW-1:0]   i_snoop_addr;
    logic            o_resp_valid;
    logic            i_resp_ready;
    logic [DW-1:0]   o_resp_data;
    logic            o_resp_err;

    always #5 i_clk = ~i_clk;

    core_amo_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_amo_valid  (i_amo_valid),
        .o_amo_ready  (o_amo_ready),
        .i_amo_op     (i_amo_op),
        .i_amo_word   (i_amo_word),
        .i_amo_addr   (i_amo_addr),
        .i_amo_wdata  (i_amo_wdata),
        .o_mem_rd_en  (o_mem_rd_en),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wstrb  (o_mem_wstrb),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_ack    (i_mem_ack),
        .i_snoop_valid(i_snoop_valid),
        .i_snoop_addr (i_snoop_addr),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_data  (o_resp_data),
        .o_resp_err   (o_resp_err)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [logic [63:0]];

    logic        r_done, r_saw_rd, r_saw_wr, r_err;
    logic [63:0] r_data, r_wdata, r_waddr;
    logic [7:0]  r_wstrb;
    int          r_lat;

    typedef struct {
        logic [3:0]  op;
        logic        word;
        logic [63:0] addr;
        logic [63:0] init;
        logic [63:0] opnd;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_strb;
        logic [63:0] exp_resp;
    } vec_t;

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        logic [63:0] k;
        k = {a[63:3], 3'b000};
        return mem.exists(k) ? mem[k] : 64'h0;
    endfunction

    task automatic mem_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] k, v;
        k = {a[63:3], 3'b000};
        v = mem_rd(a);
        for (int b = 0; b < 8; b++) begin
            if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        end
        mem[k] = v;
    endtask

    // Issues one request from an idle unit, answers memory with zero-wait acks, optionally
    // fires a snoop alongside the read ack, and holds the response for 'hold' cycles.
    task automatic run_op(input logic [3:0] op, input logic word, input logic [63:0] addr,
                          input logic [63:0] wdata, input int hold,
                          input logic snoop_rd, input logic [63:0] snoop_a);
        int n;
        r_done = 0; r_saw_rd = 0; r_saw_wr = 0; r_err = 0;
        r_data = '0; r_wdata = '0; r_waddr = '0; r_wstrb = '0; r_lat = 0;
        @(negedge i_clk);
        i_amo_valid = 1'b1;
        i_amo_op    = op;
        i_amo_word  = word;
        i_amo_addr  = addr;
        i_amo_wdata = wdata;
        @(posedge i_clk);
        @(negedge i_clk);
        i_amo_valid = 1'b0;
        n = 1;
        while (!r_done && n <= 40) begin
            i_mem_ack     = 1'b0;
            i_resp_ready  = 1'b0;
            i_snoop_valid = 1'b0;
            if (o_mem_rd_en) begin
                r_saw_rd    = 1'b1;
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem_rd(o_mem_addr);
                if (snoop_rd) begin
                    i_snoop_valid = 1'b1;
                    i_snoop_addr  = snoop_a;
                end
            end
            if (o_mem_wr_en) begin
                r_saw_wr  = 1'b1;
                r_wdata   = o_mem_wdata;
                r_wstrb   = o_mem_wstrb;
                r_waddr   = o_mem_addr;
                i_mem_ack = 1'b1;
                mem_wr(o_mem_addr, o_mem_wdata, o_mem_wstrb);
            end
            if (o_resp_valid) begin
                r_lat  = n;
                r_data = o_resp_data;
                r_err  = o_resp_err;
                for (int h = 0; h < hold; h++) begin
                    @(posedge i_clk);
                    @(negedge i_clk);
                    checks++;
                    if (o_resp_valid !== 1'b1 || o_resp_data !== r_data ||
                        o_resp_err !== r_err || o_amo_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL resp_hold[%0d]: got valid=%b data=%h err=%b ready=%b, expected valid=1 data=%h err=%b ready=0",
                                 h, o_resp_valid, o_resp_data, o_resp_err, o_amo_ready, r_data, r_err);
                    end
                end
                i_resp_ready = 1'b1;
                r_done       = 1'b1;
            end
            @(posedge i_clk);
            @(negedge i_clk);
            n++;
        end
        i_mem_ack     = 1'b0;
        i_resp_ready  = 1'b0;
        i_snoop_valid = 1'b0;
        checks++;
        if (!r_done) begin
            errors++;
            $display("FAIL op_timeout: op %0d got no response within 40 cycles, expected a response", op);
        end
        checks++;
        if (o_amo_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_resp: got %b expected 1", o_amo_ready);
        end
    endtask

    task automatic idle_snoop(input logic [63:0] a);
        @(negedge i_clk);
        i_snoop_valid = 1'b1;
        i_snoop_addr  = a;
        @(posedge i_clk);
        @(negedge i_clk);
        i_snoop_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (o_amo_ready !== 1'b1 || o_mem_rd_en !== 1'b0 || o_mem_wr_en !== 1'b0 ||
            o_resp_valid !== 1'b0 || o_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b rd=%b wr=%b rv=%b err=%b expected 1 0 0 0 0",
                     o_amo_ready, o_mem_rd_en, o_mem_wr_en, o_resp_valid, o_resp_err);
        end
        checks++;
        if (o_mem_addr !== '0 || o_mem_wdata !== '0 || o_mem_wstrb !== '0 || o_resp_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h wstrb=%h resp=%h expected all 0",
                     o_mem_addr, o_mem_wdata, o_mem_wstrb, o_resp_data);
        end
    endtask

    task automatic test_amoadd();
        mem[64'h80] = 64'h10;
        run_op(4'd1, 1'b0, 64'h80, 64'h5, 0, 1'b0, '0);
        checks++;
        if (r_wdata !== 64'h15 || r_wstrb !== 8'hFF || r_waddr !== 64'h80) begin
            errors++;
            $display("FAIL add_write: got wdata=%h wstrb=%h addr=%h expected 15 ff 80", r_wdata, r_wstrb, r_waddr);
        end
        checks++;
        if (r_data !== 64'h10 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL add_resp: got data=%h err=%b expected 10 0", r_data, r_err);
        end
        checks++;
        if (r_lat !== 3) begin
            errors++;
            $display("FAIL add_latency: got %0d cycles expected 3", r_lat);
        end
    endtask

    task automatic test_ops();
        vec_t v [11];
        v[0]  = '{4'd6, 1'b1, 64'h104, 64'h00000003_DEADBEEF, 64'h00000000_FFFFFFFE,
                  64'hFFFFFFFE_FFFFFFFE, 8'hF0, 64'h3};
        v[1]  = '{4'd0, 1'b0, 64'h180, 64'h1111, 64'h2222, 64'h2222, 8'hFF, 64'h1111};
        v[2]  = '{4'd2, 1'b0, 64'h188, 64'hFF00FF00, 64'h0FF00FF0, 64'h0F000F00, 8'hFF, 64'hFF00FF00};
        v[3]  = '{4'd3, 1'b0, 64'h190, 64'hF0, 64'h0F, 64'hFF, 8'hFF, 64'hF0};
        v[4]  = '{4'd4, 1'b0, 64'h198, 64'hF0F0, 64'hFF00, 64'h0FF0, 8'hFF, 64'hF0F0};
        v[5]  = '{4'd5, 1'b0, 64'h1A0, 64'hFFFFFFFF_FFFFFFFF, 64'h5, 64'h5, 8'hFF, 64'hFFFFFFFF_FFFFFFFF};
        v[6]  = '{4'd7, 1'b0, 64'h1A8, 64'hFFFFFFFF_FFFFFFFF, 64'h5,
                  64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'hFFFFFFFF_FFFFFFFF};
        v[7]  = '{4'd8, 1'b1, 64'h1B4, 64'h00000010_00000000, 64'h20,
                  64'h00000010_00000010, 8'hF0, 64'h10};
        v[8]  = '{4'd1, 1'b1, 64'h1B8, 64'hAAAAAAAA_FFFFFFFF, 64'h1, 64'h0, 8'h0F, 64'hFFFFFFFF_FFFFFFFF};
        v[9]  = '{4'd7, 1'b1, 64'h1C0, 64'h80000000, 64'h7FFFFFFF,
                  64'h80000000_80000000, 8'h0F, 64'hFFFFFFFF_80000000};
        v[10] = '{4'd6, 1'b0, 64'h1C8, 64'h8, 64'hFFFFFFFF_FFFFFFF0,
                  64'hFFFFFFFF_FFFFFFF0, 8'hFF, 64'h8};
        for (int i = 0; i < 11; i++) begin
            mem[{v[i].addr[63:3], 3'b000}] = v[i].init;
            run_op(v[i].op, v[i].word, v[i].addr, v[i].opnd, 0, 1'b0, '0);
            checks++;
            if (r_wdata !== v[i].exp_wdata || r_wstrb !== v[i].exp_strb) begin
                errors++;
                $display("FAIL op_vec[%0d]_write: got wdata=%h wstrb=%h expected %h %h",
                         i, r_wdata, r_wstrb, v[i].exp_wdata, v[i].exp_strb);
            end
            checks++;
            if (r_data !== v[i].exp_resp || r_err !== 1'b0) begin
                errors++;
                $display("FAIL op_vec[%0d]_resp: got data=%h err=%b expected %h 0",
                         i, r_data, r_err, v[i].exp_resp);
            end
        end
        checks++;
        if (mem_rd(64'h100) !== 64'hFFFFFFFE_DEADBEEF) begin
            errors++;
            $display("FAIL word_lane_merge: got mem=%h expected fffffffedeadbeef", mem_rd(64'h100));
        end
    endtask

    task automatic test_lr_sc();
        mem[64'h200] = 64'h77;
        run_op(4'd9, 1'b0, 64'h200, '0, 0, 1'b0, '0);
        checks++;
        if (r_data !== 64'h77 || !r_saw_rd || r_saw_wr) begin
            errors++;
            $display("FAIL lr_resp: got data=%h rd=%b wr=%b expected 77 1 0", r_data, r_saw_rd, r_saw_wr);
        end
        run_op(4'd10, 1'b0, 64'h200, 64'hAB, 0, 1'b0, '0);
        checks++;
        if (r_data !== 64'h0 || !r_saw_wr || r_saw_rd || r_wdata !== 64'hAB || r_waddr !== 64'h200) begin
            errors++;
            $display("FAIL sc_success: got data=%h wr=%b rd=%b wdata=%h addr=%h expected 0 1 0 ab 200",
                     r_data, r_saw_wr, r_saw_rd, r_wdata, r_waddr);
        end
        run_op(4'd10, 1'b0, 64'h200, 64'hCD, 0, 1'b0, '0);
        checks++;
        if (r_data !== 64'h1 || r_saw_wr) begin
            errors++;
            $display("FAIL sc_second: got data=%h wr=%b expected 1 0", r_data, r_saw_wr);
        end
    endtask

    task automatic test_snoop();
        run_op(4'd9, 1'b0, 64'h200, '0, 0, 1'b0, '0);
        idle_snoop(64'h204);
        run_op(4'd10, 1'b0, 64'h200, 64'h11, 0, 1'b0, '0);
        checks++;
        if (r_data !== 64'h1 || r_saw_wr) begin
            errors++;
            $display("FAIL sc_after_idle_snoop: got data=%h wr=%b expected 1 0", r_data, r_saw_wr);
        end
        run_op(4'd9, 1'b0, 64'h200, '0, 0, 1'b1, 64'h204);
        run_op(4'd10, 1'b0, 64'h200, 64'h22, 0, 1'b0, '0);
        checks++;
        if (r_data !== 64'h1 || r_saw_wr) begin
            errors++;
            $display("FAIL sc_after_ack_snoop: got data=%h wr=%b expected 1 0", r_data, r_saw_wr);
        end
        run_op(4'd9, 1'b0, 64'h200, '0, 0, 1'b0, '0);
        idle_snoop(64'h208);
        run_op(4'd10, 1'b0, 64'h200, 64'h33, 0, 1'b0, '0);
        checks++;
        if (r_data !== 64'h0 || !r_saw_wr || r_wdata !== 64'h33) begin
            errors++;
            $display("FAIL sc_other_granule_snoop: got data=%h wr=%b wdata=%h expected 0 1 33",
                     r_data, r_saw_wr, r_wdata);
        end
    endtask

    task automatic test_illegal();
        run_op(4'hC, 1'b0, 64'h80, 64'hFFFF, 4, 1'b0, '0);
        checks++;
        if (r_err !== 1'b1 || r_data !== 64'h0 || r_saw_rd || r_saw_wr) begin
            errors++;
            $display("FAIL illegal_op: got err=%b data=%h rd=%b wr=%b expected 1 0 0 0",
                     r_err, r_data, r_saw_rd, r_saw_wr);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        mem[64'h300] = 64'h99;
        run_op(4'd9, 1'b0, 64'h300, '0, 0, 1'b0, '0);
        @(negedge i_clk);
        i_amo_valid = 1'b1;
        i_amo_op    = 4'd0;
        i_amo_word  = 1'b0;
        i_amo_addr  = 64'h300;
        i_amo_wdata = 64'h55;
        @(posedge i_clk);
        @(negedge i_clk);
        i_amo_valid = 1'b0;
        k = 0;
        while (!o_mem_rd_en && k < 10) begin
            @(posedge i_clk);
            @(negedge i_clk);
            k++;
        end
        i_mem_ack   = 1'b1;
        i_mem_rdata = mem_rd(64'h300);
        @(posedge i_clk);
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        checks++;
        if (o_mem_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_in_wr: got wr_en=%b expected 1", o_mem_wr_en);
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        checks++;
        if (o_mem_wr_en !== 1'b0 || o_amo_ready !== 1'b1 || o_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: got wr=%b ready=%b rv=%b expected 0 1 0",
                     o_mem_wr_en, o_amo_ready, o_resp_valid);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            checks++;
            if (o_resp_valid !== 1'b0 || o_mem_rd_en !== 1'b0 || o_mem_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet[%0d]: got rv=%b rd=%b wr=%b expected 0 0 0",
                         c, o_resp_valid, o_mem_rd_en, o_mem_wr_en);
            end
        end
        run_op(4'd10, 1'b0, 64'h300, 64'h66, 0, 1'b0, '0);
        checks++;
        if (r_data !== 64'h1 || r_saw_wr) begin
            errors++;
            $display("FAIL sc_after_reset: got data=%h wr=%b expected 1 0", r_data, r_saw_wr);
        end
    endtask

    task automatic test_back_to_back();
        mem[64'h400] = 64'h1;
        for (int i = 0; i < 3; i++) begin
            run_op(4'd1, 1'b0, 64'h400, 64'h2, 0, 1'b0, '0);
            checks++;
            if (r_data !== 64'(1 + 2 * i)) begin
                errors++;
                $display("FAIL b2b_add[%0d]: got %h expected %h", i, r_data, 64'(1 + 2 * i));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst         = 1'b1;
        i_amo_valid   = 1'b0;
        i_amo_op      = '0;
        i_amo_word    = 1'b0;
        i_amo_addr    = '0;
        i_amo_wdata   = '0;
        i_mem_rdata   = '0;
        i_mem_ack     = 1'b0;
        i_snoop_valid = 1'b0;
        i_snoop_addr  = '0;
        i_resp_ready  = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        test_reset();
        test_amoadd();
        test_ops();
        test_lr_sc();
        test_snoop();
        test_illegal();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_amo_unit.md
Name: core_amo_unit

Overview:
Sequential atomic memory operation engine sitting between the core's load/store path and the data-memory/cache port.
- Accepts one AMO, LR or SC request at a time.
- Performs the read-modify-write on memory with req/ack handshakes.
- Returns the old memory value, or the SC status, to the core.
- Supports doubleword and word (32-bit lane) operands and keeps an LR reservation that other cores' writes can invalidate via a snoop input.

Parameters:
- DATA_WIDTH, 64, memory/core data width; legal values 32 or 64 (at 32, i_amo_word is ignored and every op is word-sized).
- ADDR_WIDTH, 64, byte-address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_amo_valid  in  1  request valid.
- o_amo_ready  out  1  unit can accept a request (high only in IDLE).
- i_amo_op  in  4  0 SWAP, 1 ADD, 2 AND, 3 OR, 4 XOR, 5 MAX, 6 MIN, 7 MAXU, 8 MINU, 9 LR, 10 SC, 11-15 illegal.
- i_amo_word  in  1  1 = 32-bit op, 0 = DATA_WIDTH op.
- i_amo_addr  in  ADDR_WIDTH  byte address, naturally aligned.
- i_amo_wdata  in  DATA_WIDTH  core operand; word ops use bits [31:0].
- o_mem_rd_en  out  1  memory read request.
- o_mem_wr_en  out  1  memory write request.
- o_mem_addr  out  ADDR_WIDTH  address with low log2(DATA_WIDTH/8) bits zeroed.
- o_mem_wdata  out  DATA_WIDTH  write data.
- o_mem_wstrb  out  DATA_WIDTH/8  byte enables.
- i_mem_rdata  in  DATA_WIDTH  read data, valid in the ack cycle of a read.
- i_mem_ack  in  1  completes the pending rd or wr request.
- i_snoop_valid  in  1  another agent wrote memory.
- i_snoop_addr  in  ADDR_WIDTH  address of that write.
- o_resp_valid  out  1  response valid.
- i_resp_ready  in  1  core accepts the response.
- o_resp_data  out  DATA_WIDTH  old value (word ops sign-extended); SC: 0 = success, 1 = fail.
- o_resp_err  out  1  illegal opcode.

Behaviour:
- Reset values: all outputs 0 except o_amo_ready = 1; state IDLE; reservation invalid.
- States: IDLE, RD, WR, SC_CHK, RESP.
- Accept: a request is accepted on a cycle with i_amo_valid & o_amo_ready. The unit latches op, word, addr and wdata.
- Transitions out of IDLE on accept:
  - ops 0-9 -> RD.
  - op 10 -> SC_CHK.
  - ops 11-15 -> RESP with o_resp_err = 1 and o_resp_data = 0; no memory access.
- RD: o_mem_rd_en = 1 and held until i_mem_ack. On ack, i_mem_rdata is captured.
  - LR: sets reservation (valid, granule address) and goes to RESP.
  - Other ops: go to WR.
- WR: o_mem_wr_en = 1 and held until ack, then go to RESP.
  - o_mem_wdata = f(old, operand) per op, computed from the captured old value.
  - Compares for MAX/MIN are signed; MAXU/MINU are unsigned. Ties return the core operand.
- SC_CHK (one cycle):
  - Success when reservation valid, granule address matches, and no matching snoop this cycle. Goes to WR, writing the operand (SWAP semantics); response data 0.
  - Otherwise goes to RESP with data 1 and no write.
  - The reservation is cleared in SC_CHK regardless of outcome.
- Word ops with DATA_WIDTH = 64:
  - Lane = addr[2]. Operands and compare use the selected 32 bits only.
  - o_mem_wdata carries the 32-bit result replicated in both halves.
  - o_mem_wstrb = 8'h0F for lane 0, 8'hF0 for lane 1.
  - Response data is the old lane value sign-extended to 64 bits.
- Doubleword ops: wstrb all ones.
- RESP: o_resp_valid held with stable data until i_resp_ready, then IDLE. o_amo_ready rises the cycle after the handshake.
- Minimum latency for an AMO with immediate acks is 3 cycles from accept to o_resp_valid.
- Reservation granule is DATA_WIDTH/8 bytes, compared on the masked address.
- Reservation clearing:
  - A snoop whose masked address matches clears the reservation in any state.
  - A matching snoop in the same cycle as the LR read ack leaves the reservation invalid; snoop wins.
  - A new LR overwrites the existing reservation.
  - A completed AMO write to the reserved granule by this unit also clears it.
- i_mem_ack while no request is pending is ignored.
- Reset mid-operation: the next edge returns to IDLE, deasserts mem enables and o_resp_valid, and clears the reservation. No response is produced for the aborted request.

Test Plan:
- Doubleword AMOADD: mem = 0x10, operand 0x5.
  - Required: write 0x15 with wstrb 0xFF, response 0x10, o_resp_valid 3 cycles after accept with zero-wait acks.
- Word signed AMOMIN on lane 1 (addr 0x104): upper word 0x00000003, operand 0xFFFFFFFE.
  - Required: wdata upper half 0xFFFFFFFE, wstrb 0xF0, response 0x0000000000000003.
- LR at 0x200 then SC at 0x200 with operand 0xAB.
  - Required: SC writes 0xAB and responds 0.
  - A second SC to 0x200 responds 1 with no o_mem_wr_en.
- LR at 0x200, snoop at 0x204 (same granule) while idle, then SC at 0x200.
  - Required: SC fails (1). Repeat with the snoop coinciding with the LR read ack: SC still fails.
- Opcode 4'hC.
  - Required: o_resp_err = 1, data 0, no rd/wr request.
  - Hold i_resp_ready low for 4 cycles: response stays stable, o_amo_ready stays 0.
- Assert i_rst during WR with ack withheld.
  - Required: next cycle o_mem_wr_en = 0, o_amo_ready = 1, no response; a following LR/SC pair without a new LR fails.
